// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic TXD_IDLE  = 1'b1;
    localparam logic TXD_START = 1'b0;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding buffer, advanced by an external baud tick.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 buf_full_q, buf_full_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 accept;
    logic                 load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= TXD_IDLE;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        accept     = din_valid && !buf_full_q;
        load       = 1'b0;

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (buf_full_q) begin
                        load = 1'b1;
                    end
                end
                START: begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 4'd1;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q < LAST_BIT) begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = PARITY;
`else
                        txd_d      = TXD_IDLE;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    txd_d      = TXD_IDLE;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
`endif
                STOP: begin
                    // With two stop bits the first tick only extends the high level.
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (buf_full_q) begin
                        load = 1'b1;
                    end else begin
                        txd_d   = TXD_IDLE;
                        state_d = IDLE;
                    end
                end
                default: begin
                    txd_d   = TXD_IDLE;
                    state_d = IDLE;
                end
            endcase
        end

        if (load) begin
            shift_d    = buf_q;
            buf_full_d = 1'b0;
            txd_d      = TXD_START;
            state_d    = START;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^buf_q;
`endif
        end

        // A load implies the buffer was full, so it never coincides with an accept.
        if (accept) begin
            buf_d      = din;
            buf_full_d = 1'b1;
        end
    end

    always_comb begin
        txd       = txd_q;
        din_ready = !buf_full_q;
        busy      = (state_q != IDLE) || buf_full_q;
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one- and two-stop-bit instances against a frame-level model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam logic [11:0] EXP55 = (PAR != 0) ? 12'b110010101010 : 12'b111010101010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd0, busy0, rdy0;
    logic       txd1, busy1, rdy1;

    int checks = 0;
    int errors = 0;

    // Frame-level model per instance: frame bits, position, in-frame flag, one pending byte.
    logic [15:0] frm [2];
    int          pos [2];
    int          len [2];
    bit          inf [2];
    bit          pv  [2];
    bit          line[2];
    logic [7:0]  pd  [2];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy0),
        .txd       (txd0),
        .busy      (busy0)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (rdy1),
        .txd       (txd1),
        .busy      (busy1)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line sequence of one frame, index 0 first on the wire; unused high bits stay 1.
    function automatic logic [15:0] build(input logic [7:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (PAR != 0) f[9] = ^d;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            inf[i]  = 1'b0;
            pv[i]   = 1'b0;
            line[i] = 1'b1;
            pos[i]  = 0;
            len[i]  = 0;
        end
    endtask

    task automatic check_outputs(input string when);
        check({when, "_txd0"},  16'(txd0),  16'(line[0]));
        check({when, "_busy0"}, 16'(busy0), 16'(inf[0] || pv[0]));
        check({when, "_rdy0"},  16'(rdy0),  16'(!pv[0]));
        check({when, "_txd1"},  16'(txd1),  16'(line[1]));
        check({when, "_busy1"}, 16'(busy1), 16'(inf[1] || pv[1]));
        check({when, "_rdy1"},  16'(rdy1),  16'(!pv[1]));
    endtask

    task automatic step(input bit t, input bit v, input logic [7:0] d);
        @(negedge clk);
        tick      = t;
        din_valid = v;
        din       = d;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = v && !pv[i];
            if (t) begin
                if (inf[i] && pos[i] == len[i]) inf[i] = 1'b0;
                if (!inf[i] && pv[i]) begin
                    frm[i] = build(pd[i]);
                    len[i] = 9 + PAR + (i + 1);
                    pos[i] = 0;
                    inf[i] = 1'b1;
                    pv[i]  = 1'b0;
                end
                if (inf[i]) begin
                    line[i] = frm[i][pos[i]];
                    pos[i]++;
                end else begin
                    line[i] = 1'b1;
                end
            end
            if (acc) begin
                pv[i] = 1'b1;
                pd[i] = d;
            end
        end
        #1;
        check_outputs("cyc");
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 8'h00);
            repeat (3) step(1'b0, 1'b0, 8'h00);
        end
    endtask

    // Hold an offer until the single-stop model accepts it, keeping the 4-clk tick cadence.
    task automatic offer(input logic [7:0] d);
        int c;
        bit done;
        c    = 0;
        done = 1'b0;
        while (!done && c < 200) begin
            done = !pv[0];
            step(c % 4 == 0, 1'b1, d);
            c++;
        end
    endtask

    // Reset asserted mid-cycle together with tick and din_valid; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        tick      = 1'b1;
        din_valid = 1'b1;
        din       = 8'hE7;
        #1;
        model_reset();
        check("rst_txd0", 16'(txd0), 16'd1);
        check("rst_busy0", 16'(busy0), 16'd0);
        check("rst_rdy0", 16'(rdy0), 16'd1);
        check("rst_txd1", 16'(txd1), 16'd1);
        check("rst_busy1", 16'(busy1), 16'd0);
        check("rst_rdy1", 16'(rdy1), 16'd1);
        @(posedge clk);
        #1;
        check_outputs("rst_hold");
        @(negedge clk);
        rst       = 1'b0;
        tick      = 1'b0;
        din_valid = 1'b0;
    endtask

    initial begin
        logic [11:0] cap;
        cap = '0;
        model_reset();

        do_reset();

        // 0x55 offered for one cycle, ticks every 4 clk
        step(1'b0, 1'b1, 8'h55);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 8'h00);
            cap[k] = txd0;
            repeat (3) step(1'b0, 1'b0, 8'h00);
        end
        check("frame_0x55", 16'(cap), 16'(EXP55));
        ticks(2);

        // Offer coinciding with a tick while idle: start bit waits for the next tick
        step(1'b1, 1'b1, 8'h3C);
        repeat (3) step(1'b0, 1'b0, 8'h00);
        ticks(14);

        // Back-to-back frames, third offer stalls until the buffer empties
        offer(8'hA5);
        offer(8'h3C);
        offer(8'h77);
        ticks(40);

        step(1'b0, 1'b1, 8'h07);
        ticks(14);
        step(1'b0, 1'b1, 8'hFF);
        ticks(14);

        // Reset during the 4th data bit with a byte queued
        step(1'b0, 1'b1, 8'hC3);
        ticks(5);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        do_reset();
        ticks(15);

        for (int c = 0; c < 3000; c++) begin
            step(c % 4 == 0, $urandom_range(0, 5) == 0, 8'($urandom));
        end
        ticks(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (legal range 5..8).
REQ-002 Parameter STOP_BITS, default 1, number of stop bits per frame (legal values 1 or 2).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  one-clk-wide bit-period pulse (rateclk of the baud generator); every bit lasts exactly one tick interval.
REQ-006 din  input  DATA_BITS  byte to transmit; bits above DATA_BITS do not exist.
REQ-007 din_valid  input  1  din holds a byte offered for transmission.
REQ-008 din_ready  output  1  holding buffer empty; a byte is accepted in any clk cycle where din_valid and din_ready are both 1.
REQ-009 txd  output  1  serial line; idle high; LSB first.
REQ-010 busy  output  1  high while a frame is in progress or the holding buffer is full.

Function
REQ-011 The block SHALL contain a one-entry holding buffer plus a shift register, so one byte can be queued while another is shifting out.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; transitions SHALL occur only in clk cycles where tick=1.
REQ-013 IDLE + tick + buffer full: load the shift register from the buffer, empty the buffer, txd<=0, go to START.
REQ-014 START + tick: txd<=shift[0], shift right, bit counter<=1, go to DATA.
REQ-015 DATA + tick: if bit counter < DATA_BITS, txd<=next bit, counter+1; else go to PARITY (txd<=parity) when parity is compiled in, otherwise go to STOP (txd<=1).
REQ-016 PARITY + tick: txd<=1, go to STOP.
REQ-017 STOP + tick on the final stop bit: if buffer full, behave exactly as REQ-013 (back-to-back frame, no idle gap); else go to IDLE with txd=1. With STOP_BITS=2, the first stop tick only increments the stop counter.
REQ-018 txd SHALL be a registered output that changes only in the clk cycle after a tick.
REQ-019 din_ready SHALL equal NOT buffer_full; din_valid while din_ready=0 SHALL be ignored, and buffer contents SHALL NOT change.
REQ-020 Accept and tick in the same cycle while IDLE with an empty buffer: the byte goes into the buffer, and the frame starts on the next tick, not this one.
REQ-021 Accept in the same cycle as a REQ-013/REQ-017 load: legal only when the buffer was empty before that cycle; otherwise din_ready was 0 and the offer is ignored.
REQ-022 busy SHALL equal (state != IDLE) OR buffer_full.
REQ-023 tick while IDLE with an empty buffer SHALL change nothing.

Reset
REQ-024 When rst is asserted, the block SHALL immediately set txd=1, state=IDLE, buffer empty, din_ready=1, busy=0, and clear all counters.
REQ-025 Reset mid-frame SHALL abort the frame and discard the queued byte; no partial frame resumes after release.
REQ-026 rst SHALL dominate tick and din_valid in the same cycle.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: the PARITY state exists and sends even parity (XOR of the DATA_BITS data bits) after the last data bit.
REQ-028 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent; DATA goes directly to STOP.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3 bits) and the constants TXD_IDLE=1 and TXD_START=0.
REQ-030 The block SHALL be a single module with no sub-modules; tick SHALL be driven externally by baudrate_gen.

Verification
REQ-031 Reset, then din=0x55 with valid for 1 cycle, then ticks every 4 clk -> txd per tick: 0,1,0,1,0,1,0,1,0,1 (parity off), then txd stays 1, busy=0.
REQ-032 Parity on, din=0x07 -> after data bits 1,1,1,0,0,0,0,0, the parity bit = 1, then stop = 1.
REQ-033 Offer 0xA5 then 0x3C back-to-back -> second accepted while first shifts (din_ready drops only after second); stop of frame 1 is followed directly by start of frame 2; a third offer is ignored until the buffer empties.
REQ-034 Assert din_valid in the same cycle as a tick while IDLE and empty -> txd stays 1 on that tick; start bit appears on the following tick.
REQ-035 Assert rst during the 4th data bit with a byte queued -> txd=1 immediately, busy=0, din_ready=1; subsequent ticks produce no frame.
REQ-036 STOP_BITS=2, din=0xFF -> txd high for 10 data/stop ticks after the start bit (8 data + 2 stop), then the next frame may start.
